pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides. It splits a WIDTH-bit operation into STAGES chunks and resolves one chunk per pipeline stage, with the carry rippling stage to stage. It supports add or subtract per transaction and reports carry-out and signed overflow. It is the datapath arithmetic primitive for wide operands where a single-cycle ripple adder cannot meet timing.

---
 rtl/pipelined_addsub_pkg.sv | 8 +
 rtl/adder_chunk.sv | 16 +
 rtl/pipelined_addsub.sv | 95 +++++++++
 tb/tb_pipelined_addsub.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: default sizing and parameter legality check for the pipelined adder/subtractor
package pipelined_addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  function automatic bit params_ok(int width, int stages);
    return stages >= 1 && width % stages == 0;
  endfunction
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: CW-bit combinational add with carry-in, carry-out and carry into the MSB
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] sum,
  output logic          co,
  output logic          cm
);
  always_comb begin
    {co, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
    cm = a[CW-1] ^ b[CW-1] ^ sum[CW-1];
  end
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: elastic STAGES-deep chunked add/subtract with carry rippling between stages
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int CW = WIDTH / STAGES;
  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic v_q [STAGES];
  logic c_q [STAGES];
  logic o_q [STAGES];
  logic v_in [STAGES];
  logic c_in [STAGES];
  logic rdy [STAGES+1];
  assign rdy[STAGES] = out_ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0] cs;
    logic co, cm;
    logic [WIDTH-1:0] s_nx;
    // Subtraction becomes A + ~B + ~Cin right at capture, so every stage just adds.
    if (k == 0) begin : g_first
      assign a_in[0] = A;
      assign b_in[0] = Sub ? ~B : B;
      assign c_in[0] = Cin ^ Sub;
      assign v_in[0] = in_valid;
      assign s_in[0] = '0;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
      assign s_in[k] = s_q[k-1];
    end
    assign rdy[k] = !v_q[k] || rdy[k+1];
    adder_chunk #(.CW(CW)) u_add (
      .a  (a_in[k][k*CW +: CW]),
      .b  (b_in[k][k*CW +: CW]),
      .ci (c_in[k]),
      .sum(cs),
      .co (co),
      .cm (cm)
    );
    always_comb begin
      s_nx = s_in[k];
      s_nx[k*CW +: CW] = cs;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
      end else if (rdy[k]) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nx;
          c_q[k] <= co;
          o_q[k] <= cm ^ co;
        end
      end
    end
  end
  assign in_ready = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign Sum = s_q[STAGES-1];
  assign Cout = c_q[STAGES-1];
  assign Ovf = o_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench with an arithmetic reference model, WIDTH=8 STAGES=2
module tb_pipelined_addsub;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic Cin = 1'b0;
  logic Sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] Sum;
  logic Cout, Ovf;
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  int vec_i = 0;
  logic [9:0] q[$];
  logic stall_q = 1'b0;
  logic [9:0] held = '0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  // Reference: true integer arithmetic, signed range check for overflow, borrow test for subtract.
  function automatic logic [9:0] model(int a, int b, int ci, int sub);
    int sa, sb, r, sr;
    logic co, ov;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    if (sub != 0) begin
      r = a - b - ci;
      sr = sa - sb - ci;
      co = r >= 0;
    end else begin
      r = a + b + ci;
      sr = sa + sb + ci;
      co = r > 255;
    end
    ov = sr > 127 || sr < -128;
    return {ov, co, 8'(r & 255)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", {22'd0, Ovf, Cout, Sum}, {22'd0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got result %0h, expected none", {Ovf, Cout, Sum});
        end else begin
          chk("result", {22'd0, Ovf, Cout, Sum}, {22'd0, q.pop_front()});
          n_pop++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(A, B, Cin, Sub));
      stall_q <= out_valid && !out_ready;
      held <= {Ovf, Cout, Sum};
    end
  end

  task automatic new_vec();
    A = 8'($urandom);
    B = 8'($urandom);
    Sub = vec_i[0];
    Cin = vec_i[1];
    vec_i++;
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b, logic ci, logic su);
    bit acc = 0;
    int cyc = 0;
    A = a; B = b; Cin = ci; Sub = su;
    in_valid = 1'b1;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic stream(int n, output int cyc);
    int cnt = 0;
    bit acc;
    cyc = 0;
    new_vec();
    in_valid = 1'b1;
    while (cnt < n && cyc < 4 * n) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        cnt++;
        if (cnt < n) new_vec();
      end
    end
    in_valid = 1'b0;
    chk("stream_count", cnt, n);
  endtask

  task automatic drain();
    int cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pops, cnt;
    bit acc;
    chk("pin_add", 32'(model(8'h0F, 8'h01, 0, 0)), 32'h010);
    chk("pin_ovf", 32'(model(8'h7F, 8'h01, 0, 0)), 32'h280);
    chk("pin_wrap", 32'(model(8'hFF, 8'h01, 0, 0)), 32'h100);
    chk("pin_sub", 32'(model(8'h05, 8'h07, 0, 1)), 32'h0FE);
    chk("pin_subovf", 32'(model(8'h80, 8'h01, 0, 1)), 32'h37F);
    in_valid = 1'b1;
    A = 8'h55; B = 8'h11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", {22'd0, Ovf, Cout, Sum}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_ghost", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_2", 32'(out_valid), 32'd1);
    chk("dir_0f_01", {22'd0, Ovf, Cout, Sum}, 32'h010);
    @(posedge clk);
    #1;
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    drain();
    stream(100, cyc);
    chk("throughput", cyc, 100);
    drain();
    // Backpressure: stalled output with continuous offers fills exactly STAGES slots.
    pops = n_pop;
    out_ready = 1'b0;
    cnt = 0;
    new_vec();
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cnt++;
        new_vec();
      end
    end
    chk("fill_count", cnt, S);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("drain_pops", n_pop - pops, S);
    out_ready = 1'b0;
    send(8'hA5, 8'h3C, 1'b1, 1'b1);
    send(8'h12, 8'hF0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", {22'd0, Ovf, Cout, Sum}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    pops = n_pop;
    send(8'h12, 8'h34, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_result", {22'd0, Ovf, Cout, Sum}, 32'h047);
    drain();
    chk("post_rst_pops", n_pop - pops, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
